// File: rtl/gji_pkg.sv
// gji_pkg: shared FSM states, default sizes and the saturation helper for gauss_jordan_inv.
package gji_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, PIVOT, SWAP, RECIP, NORM, ELIM, OUT} state_t;
  localparam int DEF_N = 4;
  localparam int DEF_W = 32;
  localparam int DEF_FRAC = 16;
  // Clamp a wide signed value into the signed range of w bits (w <= 64).
  function automatic logic signed [127:0] sat(input logic signed [127:0] x, input int w);
    logic signed [127:0] hi;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    return x > hi ? hi : x < -hi - 128'sd1 ? -hi - 128'sd1 : x;
  endfunction
endpackage

// File: rtl/gji_seq_div.sv
// gji_seq_div: restoring signed divider, one quotient bit per cycle over W+FRAC bits,
// result saturated to W bits; start samples the operands, done pulses with quo.
module gji_seq_div import gji_pkg::*; #(
  parameter int W = DEF_W,
  parameter int FRAC = DEF_FRAC
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [W+FRAC-1:0] num,
  input  logic [W-1:0] den,
  output logic done,
  output logic [W-1:0] quo
);
  localparam int NB = W + FRAC;
  logic [NB-1:0] qr, qn;
  logic [W-1:0] rem, dm;
  logic [W:0] t;
  logic ge, neg, run;
  logic [7:0] cnt;
  assign t = {rem, qr[NB-1]};
  assign ge = t >= {1'b0, dm};
  assign qn = {qr[NB-2:0], ge};
  function automatic logic [W-1:0] qsat(input logic [NB-1:0] q, input logic n);
    logic signed [127:0] v;
    v = $signed(128'(q));
    v = sat(n ? -v : v, W);
    return v[W-1:0];
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      run <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      qr <= '0;
      rem <= '0;
      dm <= '0;
      neg <= 1'b0;
      quo <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        run <= 1'b1;
        cnt <= '0;
        rem <= '0;
        qr <= num[NB-1] ? -num : num;
        dm <= den[W-1] ? -den : den;
        neg <= num[NB-1] ^ den[W-1];
      end else if (run) begin
        rem <= ge ? W'(t - {1'b0, dm}) : t[W-1:0];
        qr <= qn;
        cnt <= cnt + 8'd1;
        if (cnt == 8'(NB - 1)) begin
          run <= 1'b0;
          done <= 1'b1;
          quo <= qsat(qn, neg);
        end
      end
    end
endmodule

// File: rtl/gauss_jordan_inv.sv
// gauss_jordan_inv: streaming fixed-point matrix inverse by Gauss-Jordan on an [A | I] store.
// Define GJI_PARTIAL_PIVOT_EN for largest-magnitude pivoting with row swap; otherwise row k pivots.
module gauss_jordan_inv import gji_pkg::*; #(
  parameter int N = DEF_N,
  parameter int W = DEF_W,
  parameter int FRAC = DEF_FRAC
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [W-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [W-1:0] out_data,
  output logic out_last,
  output logic out_singular,
  output logic busy
);
  localparam int RB = $clog2(N);
  localparam int CB = RB + 1;
  localparam logic [RB-1:0] LR = RB'(N - 1);
  localparam logic [CB-1:0] LC = CB'(2 * N - 1);
  localparam logic signed [W-1:0] ONE = W'(1) << FRAC;
  state_t state;
  logic signed [W-1:0] m [N][2*N];
  logic signed [W-1:0] recip, fac, fcur, div_quo;
  logic [RB-1:0] r, c, k, i, piv, prow, next_i;
  logic [CB-1:0] j, kc;
  logic sing, div_start, div_done, last_i;
  function automatic logic signed [W-1:0] satw(input logic signed [127:0] x);
    logic signed [127:0] t;
    t = sat(x, W);
    return t[W-1:0];
  endfunction
  function automatic logic signed [W-1:0] mulq(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = (2 * W)'(a) * (2 * W)'(b);
    return satw(128'(p >>> FRAC));
  endfunction
  function automatic logic signed [W-1:0] subs(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    return satw(128'(a) - 128'(b));
  endfunction
  function automatic logic [W:0] mag(input logic signed [W-1:0] a);
    logic signed [W:0] e;
    e = (W + 1)'(a);
    return e < 0 ? -e : e;
  endfunction
  assign kc = {1'b0, k};
  // Row factor is captured at column 0 because the row's own column k is overwritten mid-row.
  assign fcur = j == '0 ? m[i][kc] : fac;
  assign last_i = i == LR || (i == RB'(N - 2) && k == LR);
  assign next_i = (i + RB'(1) == k) ? i + RB'(2) : i + RB'(1);
  assign in_ready = state == IDLE || state == LOAD;
  assign busy = state != IDLE;
  assign out_valid = state == OUT;
  assign out_last = state == OUT && r == LR && c == LR;
  assign out_singular = state == OUT && sing;
  assign out_data = (state == OUT && !sing) ? m[r][CB'(N) + {1'b0, c}] : '0;
  always_comb begin
    piv = k;
`ifdef GJI_PARTIAL_PIVOT_EN
    for (int q = 0; q < N; q++)
      if (RB'(q) > k && mag(m[q][kc]) > mag(m[piv][kc])) piv = RB'(q);
`endif
  end
  gji_seq_div #(.W(W), .FRAC(FRAC)) u_div (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .num((W + FRAC)'(1) << (2 * FRAC)),
    .den(m[k][kc]),
    .done(div_done),
    .quo(div_quo)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      {r, c, k, i, prow, j} <= '0;
      recip <= '0;
      fac <= '0;
      sing <= 1'b0;
      div_start <= 1'b0;
      for (int q = 0; q < N; q++)
        for (int p = 0; p < 2 * N; p++) m[q][p] <= '0;
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE, LOAD: if (in_valid) begin
          m[r][{1'b0, c}] <= in_data;
          if (state == IDLE)
            for (int a = 0; a < N; a++)
              for (int b = 0; b < N; b++) m[a][N+b] <= a == b ? ONE : '0;
          c <= c == LR ? '0 : c + RB'(1);
          r <= c == LR ? (r == LR ? '0 : r + RB'(1)) : r;
          k <= '0;
          sing <= 1'b0;
          state <= (r == LR && c == LR) ? PIVOT : LOAD;
        end
        PIVOT: begin
          prow <= piv;
          if (m[piv][kc] == '0) begin
            sing <= 1'b1;
            state <= OUT;
          end else if (piv != k) state <= SWAP;
          else begin
            div_start <= 1'b1;
            state <= RECIP;
          end
        end
        SWAP: begin
          for (int q = 0; q < 2 * N; q++) begin
            m[k][q] <= m[prow][q];
            m[prow][q] <= m[k][q];
          end
          div_start <= 1'b1;
          state <= RECIP;
        end
        RECIP: if (div_done) begin
          recip <= div_quo;
          j <= '0;
          state <= NORM;
        end
        NORM: begin
          m[k][j] <= mulq(m[k][j], recip);
          j <= j + CB'(1);
          if (j == LC) begin
            j <= '0;
            i <= k == '0 ? RB'(1) : '0;
            state <= ELIM;
          end
        end
        ELIM: begin
          fac <= fcur;
          m[i][j] <= subs(m[i][j], mulq(fcur, m[k][j]));
          j <= j + CB'(1);
          if (j == LC) begin
            j <= '0;
            if (!last_i) i <= next_i;
            else if (k == LR) state <= OUT;
            else begin
              k <= k + RB'(1);
              state <= PIVOT;
            end
          end
        end
        OUT: if (out_ready) begin
          if (r == LR && c == LR) begin
            {r, c} <= '0;
            sing <= 1'b0;
            state <= IDLE;
          end else begin
            c <= c == LR ? '0 : c + RB'(1);
            r <= c == LR ? r + RB'(1) : r;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_gauss_jordan_inv.sv
// tb_gauss_jordan_inv: directed table-driven bench for gauss_jordan_inv (N=4) plus an N=2 pivoting case.
module tb_gauss_jordan_inv;
  localparam logic [31:0] ONE = 32'h0001_0000;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic in_valid, in_ready, out_valid, out_ready, out_last, out_singular, busy;
  logic [31:0] in_data, out_data;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_out_singular, b_busy;
  logic [31:0] b_in_data, b_out_data;
  int tests = 0;
  int fails = 0;
  typedef struct {
    string name;
    logic [31:0] a [16];
    logic [31:0] e [16];
    logic sing;
  } vec_t;
  vec_t vecs [5];
  logic [31:0] b_a [4];
  logic [31:0] b_e [4];
  logic b_sing;

  gauss_jordan_inv dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_singular(out_singular), .busy(busy)
  );
  gauss_jordan_inv #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .out_singular(b_out_singular), .busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " in_ready"}, in_ready, 1);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " out_data"}, out_data, 0);
    check({tag, " out_last"}, out_last, 0);
    check({tag, " out_singular"}, out_singular, 0);
    check({tag, " busy"}, busy, 0);
  endtask

  task automatic load4(input int v, input int count);
    for (int e = 0; e < count; e++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = vecs[v].a[e];
      check($sformatf("%s in_ready[%0d]", vecs[v].name, e), in_ready, 1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data = '0;
  endtask

  task automatic drain4(input int v, input bit stall);
    int beat;
    int cyc;
    bit hv;
    logic [31:0] held;
    beat = 0;
    cyc = 0;
    hv = 0;
    held = '0;
    while (beat < 16 && cyc < 5000) begin
      @(negedge clk);
      out_ready = stall ? cyc[0] : 1'b1;
      if (hv && out_valid) check($sformatf("%s hold beat%0d", vecs[v].name, beat), out_data, held);
      if (out_valid && out_ready) begin
        check($sformatf("%s beat%0d data", vecs[v].name, beat), out_data, vecs[v].e[beat]);
        check($sformatf("%s beat%0d singular", vecs[v].name, beat), out_singular, vecs[v].sing);
        check($sformatf("%s beat%0d last", vecs[v].name, beat), out_last, beat == 15);
        beat++;
        hv = 0;
      end else if (out_valid) begin
        held = out_data;
        hv = 1;
      end
      cyc++;
      @(posedge clk);
    end
    check($sformatf("%s beats", vecs[v].name), beat, 16);
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("%s idle after", vecs[v].name), {out_valid, busy}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int v = 0; v < 5; v++)
      for (int e = 0; e < 16; e++) begin
        vecs[v].a[e] = (e % 5 == 0) ? ONE : 32'h0;
        vecs[v].e[e] = (e % 5 == 0) ? ONE : 32'h0;
        vecs[v].sing = 1'b0;
      end
    vecs[0].name = "ident";
    vecs[1].name = "diag";
    vecs[1].a[0] = 32'h0002_0000; vecs[1].a[5] = 32'h0004_0000;
    vecs[1].a[10] = 32'h0008_0000; vecs[1].a[15] = 32'h0000_8000;
    vecs[1].e[0] = 32'h0000_8000; vecs[1].e[5] = 32'h0000_4000;
    vecs[1].e[10] = 32'h0000_2000; vecs[1].e[15] = 32'h0002_0000;
    vecs[2].name = "lower";
    vecs[2].a[0] = 32'h0002_0000; vecs[2].a[4] = 32'h0002_0000; vecs[2].a[5] = 32'h0002_0000;
    vecs[2].e[0] = 32'h0000_8000; vecs[2].e[4] = 32'hFFFF_8000; vecs[2].e[5] = 32'h0000_8000;
    vecs[3].name = "upper";
    vecs[3].a[1] = ONE;
    vecs[3].e[1] = 32'hFFFF_0000;
    vecs[4].name = "rowzero";
    vecs[4].a[10] = 32'h0;
    vecs[4].sing = 1'b1;
    for (int e = 0; e < 16; e++) vecs[4].e[e] = 32'h0;
    b_a = '{32'h0, ONE, ONE, 32'h0};
`ifdef GJI_PARTIAL_PIVOT_EN
    b_e = '{32'h0, ONE, ONE, 32'h0};
    b_sing = 1'b0;
`else
    b_e = '{32'h0, 32'h0, 32'h0, 32'h0};
    b_sing = 1'b1;
`endif
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    check("n2 reset busy", b_busy, 0);
    rst = 1'b0;
    for (int v = 0; v < 5; v++) begin
      load4(v, 16);
      drain4(v, 1'b0);
    end
    // Back-pressure: same vectors with out_ready toggling every cycle.
    load4(3, 16);
    drain4(3, 1'b1);
    load4(1, 16);
    drain4(1, 1'b1);
    // Abort in the middle of column-0 elimination, then a clean identity run.
    load4(3, 16);
    repeat (65) @(posedge clk);
    @(negedge clk);
    check("mid-elim busy", busy, 1);
    #2 rst = 1'b1;
    #1 check_reset("mid-elim reset");
    @(negedge clk);
    rst = 1'b0;
    load4(0, 16);
    drain4(0, 1'b0);
    // Abort partway through loading; the next element must be element 0.
    load4(1, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load4(0, 16);
    drain4(0, 1'b0);
    // N=2 anti-diagonal matrix: needs a row swap to be invertible.
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      b_in_valid = 1'b1;
      b_in_data = b_a[e];
      @(posedge clk);
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    begin
      int beat;
      int cyc;
      beat = 0;
      cyc = 0;
      while (beat < 4 && cyc < 2000) begin
        @(negedge clk);
        b_out_ready = 1'b1;
        if (b_out_valid) begin
          check($sformatf("n2 beat%0d data", beat), b_out_data, b_e[beat]);
          check($sformatf("n2 beat%0d singular", beat), b_out_singular, b_sing);
          check($sformatf("n2 beat%0d last", beat), b_out_last, beat == 3);
          beat++;
        end
        cyc++;
        @(posedge clk);
      end
      check("n2 beats", beat, 4);
      @(negedge clk);
      b_out_ready = 1'b0;
      check("n2 idle after", {b_out_valid, b_busy}, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gauss_jordan_inv.md
GAUSS_JORDAN_INV -- requirements
Module: gauss_jordan_inv

Interface
REQ-001 SHALL have parameter N, default 4, giving the matrix dimension (legal 2..8).
REQ-002 SHALL have parameter W, default 32, giving the signed fixed-point element width.
REQ-003 SHALL have parameter FRAC, default 16, giving the fractional bits (legal 1..W-2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the input element is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts an input element.
REQ-008 SHALL have port in_data, input, W bits: the matrix element, row-major.
REQ-009 SHALL have port out_valid, output, 1 bit: the output element is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the element.
REQ-011 SHALL have port out_data, output, W bits: the inverse element, row-major.
REQ-012 SHALL have port out_last, output, 1 bit: marks element N*N-1.
REQ-013 SHALL have port out_singular, output, 1 bit: the matrix was found singular (valid with out_valid).
REQ-014 SHALL have port busy, output, 1 bit: the block is not in IDLE.

Function
REQ-015 SHALL transfer an element only on a clock edge where valid and ready are both high; data SHALL hold stable while valid is high and ready is low.
REQ-016 SHALL sequence through states IDLE, LOAD, PIVOT, SWAP, RECIP, NORM, ELIM, OUT.
REQ-017 SHALL move from IDLE to LOAD on the first accepted element, and from LOAD to PIVOT after N*N elements; in_ready SHALL be high only in IDLE and LOAD.
REQ-018 SHALL keep an augmented [A | I] store; loading SHALL write A, and the I half SHALL be initialised to identity (1<<FRAC on the diagonal).
REQ-019 SHALL, for each column k from 0 to N-1: PIVOT selects a row; SWAP exchanges rows (0 cycles when no exchange is needed); RECIP computes recip = (1<<2*FRAC)/pivot; NORM multiplies row k by recip; ELIM computes row_i -= a[i][k]*row_k for every i != k.
REQ-020 SHALL compute each product as a 2W-bit value, shift it arithmetically right by FRAC, then saturate it to W bits; add and subtract SHALL also saturate.
REQ-021 SHALL process one element of 2N columns per cycle in NORM and ELIM.
REQ-022 SHALL treat a selected pivot equal to 0 as singular: go to OUT and stream N*N zeros with out_singular=1.
REQ-023 SHALL, in OUT, stream the N*N right-half elements and assert out_last on the final one; the final handshake SHALL return the block to IDLE.
REQ-024 SHALL hold out_data stable under back-pressure; out_valid SHALL be high only in OUT.

Reset
REQ-025 SHALL, on rst, immediately go to IDLE with in_ready=1, out_valid=0, out_data=0, out_last=0, out_singular=0, busy=0, and cancel any divider operation.
REQ-026 SHALL, after rst is asserted mid-operation, discard all partial data; the next accepted element SHALL be element 0.

Configuration
REQ-027 SHALL, with macro GJI_PARTIAL_PIVOT_EN defined, choose in PIVOT the row r>=k with the largest |a[r][k]|, lowest index on ties.
REQ-028 SHALL, with GJI_PARTIAL_PIVOT_EN undefined, use row k as pivot with no SWAP; a[k][k]==0 SHALL then be reported singular.

Structure
REQ-029 SHALL place the state enum, the default N/W/FRAC constants and the saturate function in package gji_pkg.
REQ-030 SHALL use one sub-module, gji_seq_div: a restoring signed divider taking W+FRAC cycles, with start/done handshake.

Verification
REQ-031 SHALL cover: N=4 identity input -> identity output (diagonal 0x00010000, others 0), out_singular=0.
REQ-032 SHALL cover: diag(2,4,8,0.5) -> diag 0x00008000, 0x00004000, 0x00002000, 0x00020000.
REQ-033 SHALL cover: N=2 [[0,1],[1,0]] -> same matrix with the macro defined; out_singular=1 with it undefined.
REQ-034 SHALL cover: row 2 all zero -> 16 zero beats, out_singular=1, out_last on beat 16.
REQ-035 SHALL cover: out_ready toggling 1/0 each cycle -> output sequence identical to the no-stall case, no element dropped or duplicated.
REQ-036 SHALL cover: rst pulsed during ELIM, then a new identity load -> correct identity output, with no residue from the aborted run.
